regfile_mp: RTL

Parametrised multi-read-port integer register file for the core. It replaces the fixed two-port file with the following additions:
- configurable width, depth and read-port count;
- a synchronous write port from writeback;
- write-to-read bypass;
- a post-reset clear sequencer;
- a per-register pending (scoreboard) bit for decode hazard checks.

It sits between id (reads, issue marking) and wb (writes).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 33 +++
 rtl/regfile_mp.sv | 90 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

   typedef enum logic [0:0] {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

   function automatic int rf_aw(input int nregs);
      return (nregs > 1) ? $clog2(nregs) : 1;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/issue bus between id, wb and the register file.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
);
   localparam int AW = rf_aw(NREGS);

   logic [NRD*AW-1:0]   raddr_i;
   logic [NRD*XLEN-1:0] rdata_o;
   logic [NRD-1:0]      rbusy_o;
   logic                we_i;
   logic [AW-1:0]       waddr_i;
   logic [XLEN-1:0]     wdata_i;
   logic                set_busy_i;
   logic [AW-1:0]       set_addr_i;
   logic                ready_o;

   modport slave (
      input  raddr_i, we_i, waddr_i, wdata_i, set_busy_i, set_addr_i,
      output rdata_o, rbusy_o, ready_o
   );

   modport master (
      output raddr_i, we_i, waddr_i, wdata_i, set_busy_i, set_addr_i,
      input  rdata_o, rbusy_o, ready_o
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits; a same-cycle set beats a clear since the new producer is younger.
module regfile_scoreboard #(
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_run,
   input  logic             i_set,
   input  logic [AW-1:0]    i_set_addr,
   input  logic             i_clr,
   input  logic [AW-1:0]    i_clr_addr,
   output logic [NREGS-1:0] o_busy
);
   logic [NREGS-1:0] r_busy;

   // Bit 0 is only ever written by reset, so x0 can never look pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= {NREGS{1'b0}};
      end else if (i_run) begin
         for (int i = 1; i < NREGS; i++) begin
            if (i_set && (i_set_addr == AW'(i))) begin
               r_busy[i] <= 1'b1;
            end else if (i_clr && (i_clr_addr == AW'(i))) begin
               r_busy[i] <= 1'b0;
            end
         end
      end
   end

   assign o_busy = r_busy;
endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write bypass, post-reset clear sweep
// and a pending-bit scoreboard for decode hazard checks.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
) (
   input  logic        clk,
   input  logic        rst,
   regfile_mp_if.slave bus
);
   localparam int AW = rf_aw(NREGS);

   rf_state_t           r_state;
   logic [AW-1:0]       r_clr_idx;
   logic                r_ready;
   logic [XLEN-1:0]     r_mem [1:NREGS-1];
   logic                w_run;
   logic                w_wr;
   logic [NREGS-1:0]    w_busy;
   logic [NRD*XLEN-1:0] w_rdata;
   logic [NRD-1:0]      w_rbusy;

   assign w_run = (r_state == RF_RUN);
   assign w_wr  = w_run && bus.we_i && (bus.waddr_i != {AW{1'b0}});

   // Clear sweep walks entries 1..NREGS-1; ready follows one cycle after entering RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= RF_CLEAR;
         r_clr_idx <= AW'(1);
         r_ready   <= 1'b0;
      end else begin
         r_ready <= w_run;
         if (r_state == RF_CLEAR) begin
            r_clr_idx <= r_clr_idx + AW'(1);
            if (r_clr_idx == AW'(NREGS - 1)) begin
               r_state <= RF_RUN;
            end
         end
      end
   end

   // Data array carries no reset so it can map onto RAM or plain flops.
   always_ff @(posedge clk) begin
      if (r_state == RF_CLEAR) begin
         r_mem[r_clr_idx] <= {XLEN{1'b0}};
      end else if (w_wr) begin
         r_mem[bus.waddr_i] <= bus.wdata_i;
      end
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .i_run      (w_run),
      .i_set      (bus.set_busy_i),
      .i_set_addr (bus.set_addr_i),
      .i_clr      (w_wr),
      .i_clr_addr (bus.waddr_i),
      .o_busy     (w_busy)
   );

   // Each port independently: x0 reads zero, a same-cycle write bypasses and masks busy.
   always_comb begin
      w_rdata = {NRD*XLEN{1'b0}};
      w_rbusy = {NRD{1'b0}};
      for (int k = 0; k < NRD; k++) begin
         if (!w_run || (bus.raddr_i[k*AW +: AW] == {AW{1'b0}})) begin
            w_rdata[k*XLEN +: XLEN] = {XLEN{1'b0}};
            w_rbusy[k]              = 1'b0;
         end else if (w_wr && (bus.waddr_i == bus.raddr_i[k*AW +: AW])) begin
            w_rdata[k*XLEN +: XLEN] = bus.wdata_i;
            w_rbusy[k]              = 1'b0;
         end else begin
            w_rdata[k*XLEN +: XLEN] = r_mem[bus.raddr_i[k*AW +: AW]];
            w_rbusy[k]              = w_busy[bus.raddr_i[k*AW +: AW]];
         end
      end
   end

   assign bus.rdata_o = w_rdata;
   assign bus.rbusy_o = w_rbusy;
   assign bus.ready_o = r_ready;
endmodule
